// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
// Holds the FSM state encoding, default widths and an index-width helper.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ_DEF    = 4;
    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned MAX_BURST_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or above rr_ptr, wrapping.
// Ports: req (request vector), rr_ptr (scan start), idx (winner), any (|req).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned num_req = NUM_REQ_DEF,
    localparam int unsigned IW      = idx_w(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      idx,
    output logic               any
);

    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] NR = PW'(num_req);

    logic [PW-1:0] pos;

    // Scan from the far end back toward rr_ptr so the last hit,
    // i.e. the one nearest rr_ptr, is the one that sticks.
    always_comb begin
        idx = '0;
        pos = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + PW'(k);
            if (pos >= NR) begin
                pos = pos - NR;
            end
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between requesters,
// granting bursts of up to max_burst words and honouring fifo_full.
// Ports: clk, rst (async active-low), req/req_data (requesters),
//        gnt (one-hot grant), fifo_full/fifo_wr_en/fifo_wr_data (FIFO side),
//        busy (in BURST), owner (current or last burst owner).
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned num_req    = NUM_REQ_DEF,
    parameter  int unsigned fifo_width = FIFO_WIDTH_DEF,
    parameter  int unsigned max_burst  = MAX_BURST_DEF,
    localparam int unsigned OW         = idx_w(num_req),
    localparam int unsigned CW         = $clog2(max_burst) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req-1:0]            req,
    input  logic [num_req*fifo_width-1:0] req_data,
    output logic [num_req-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [fifo_width-1:0]         fifo_wr_data,
    output logic                          busy,
    output logic [OW-1:0]                 owner
);

    localparam logic [CW-1:0] LAST = CW'(max_burst - 1);
    localparam logic [OW-1:0] TOP  = OW'(num_req - 1);

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    logic [OW-1:0] pick_idx;
    logic          pick_any;
    logic          own_req;
    logic          accept;

    rr_pick #(
        .num_req (num_req)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign own_req = req[owner_q];

    // fifo_full gates the write in the same cycle, so a full FIFO
    // is never written and the word stays with its requester.
    assign accept = (state_q == BURST) && own_req && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
                // Burst ends on abandon or on the last word; the next
                // scan starts just past the owner for fairness.
                if (!own_req || (accept && burst_cnt_q == LAST)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == TOP) ? '0 : owner_q + OW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt          = '0;
        gnt[owner_q] = accept;
        fifo_wr_en   = accept;
        fifo_wr_data = '0;
        if (state_q == BURST) begin
            fifo_wr_data = req_data[owner_q*fifo_width +: fifo_width];
        end
    end

    assign busy  = (state_q == BURST);
    assign owner = owner_q;

    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (!rst) $onehot0(gnt)
    );

    a_no_overrun: assert property (
        @(posedge clk) disable iff (!rst) !(fifo_wr_en && fifo_full)
    );

endmodule
